// File: rtl/gps_feed_pkg.sv
// gps_feed_pkg: definitions shared by the GPS IF sample feed blocks.
//   WORD_WIDTH        width of one RX FIFO word (16 bits)
//   fetch_state_t     states of the FIFO fetch FSM in sample_unpacker
//   samples_per_word  number of samples packed in one FIFO word
package gps_feed_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_t;

    function automatic int samples_per_word(input int sample_width);
        return WORD_WIDTH / sample_width;
    endfunction

endpackage

// File: rtl/sample_unpacker_if.sv
// sample_unpacker_if: groups the RX FIFO read port and the sample output port
// of sample_unpacker.
//   fifo_rd_empty  FIFO -> unpacker  FIFO empty flag
//   fifo_rd_data   FIFO -> unpacker  read data, valid the cycle after fifo_rd_req
//   fifo_rd_req    unpacker -> FIFO  read strobe, never asserted while empty
//   sample_req     front end -> unpacker  one-cycle request for the next sample
//   sample_out     unpacker -> front end  unpacked sample
//   sample_valid   unpacker -> front end  one-cycle pulse qualifying sample_out
//   underrun       unpacker -> front end  one-cycle pulse, request found no sample
//
// Handshake semantics: the FIFO side is a non-show-ahead read port. A read
// happens in exactly the cycles where fifo_rd_req is 1 (it is only raised
// while fifo_rd_empty is 0), and the word appears on fifo_rd_data in the next
// cycle. Each sample_req cycle is answered one cycle later by exactly one of
// sample_valid or underrun; there is no back-pressure on the sample side.
//
// Modports: master = the unpacker, slave = the environment (FIFO + front end).
interface sample_unpacker_if #(
    parameter int SAMPLE_WIDTH = 2
);
    logic                    fifo_rd_empty;
    logic [15:0]             fifo_rd_data;
    logic                    fifo_rd_req;
    logic                    sample_req;
    logic [SAMPLE_WIDTH-1:0] sample_out;
    logic                    sample_valid;
    logic                    underrun;

    modport master (
        input  fifo_rd_empty,
        input  fifo_rd_data,
        output fifo_rd_req,
        input  sample_req,
        output sample_out,
        output sample_valid,
        output underrun
    );

    modport slave (
        output fifo_rd_empty,
        output fifo_rd_data,
        input  fifo_rd_req,
        output sample_req,
        input  sample_out,
        input  sample_valid,
        input  underrun
    );
endinterface

// File: rtl/sample_unpacker.sv
// sample_unpacker: reads 16-bit words from the Ethernet RX FIFO and hands them
// out one GPS IF sample at a time on request of the front-end rate generator.
//
// Parameters
//   SAMPLE_WIDTH  bits per sample (1, 2, 4 or 8)
//   MSB_FIRST     1: first sample is word[15 -: SAMPLE_WIDTH]
//                 0: first sample is word[SAMPLE_WIDTH-1:0]
// Ports
//   clk             FIFO read-side clock
//   reset_n         asynchronous active-low reset
//   bus             sample_unpacker_if.master (FIFO read port + sample port)
//   underrun_count  saturating count of underrun pulses (only when the macro
//                   SAMPLE_UNPACKER_UNDERRUN_CNT_EN is defined)
//   fetch_state     debug view of the fetch FSM state
//
// Storage: a current-word shift register with a remaining-sample count and a
// one-word prefetch register. The fetch FSM keeps the prefetch filled so that
// consecutive words stream without a bubble.
module sample_unpacker
    import gps_feed_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 2,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sample_unpacker_if.master        bus,
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
    output logic [15:0]              underrun_count,
`endif
    output fetch_state_t             fetch_state
);

    localparam int SPW   = samples_per_word(SAMPLE_WIDTH);
    localparam int CNT_W = $clog2(SPW + 1);

    fetch_state_t            state_q;
    logic [WORD_WIDTH-1:0]   cur_q;
    logic [WORD_WIDTH-1:0]   pf_q;
    logic                    pf_valid_q;
    logic [CNT_W-1:0]        count_q;

    logic                    start_fetch;
    logic                    take_sample;
    logic                    load_cur;
    logic [SAMPLE_WIDTH-1:0] next_slice;
    logic [WORD_WIDTH-1:0]   cur_shifted;

    always_comb begin
        // Gated by reset_n so the read strobe is low for the whole reset,
        // even if the FIFO already holds data.
        start_fetch = reset_n && (state_q == F_IDLE) && !pf_valid_q
                      && !bus.fifo_rd_empty;
        take_sample = bus.sample_req && (count_q != '0);
        // Refill either when the current word is exhausted or when the last
        // sample leaves this cycle; the latter is what avoids the bubble.
        load_cur    = pf_valid_q &&
                      ((count_q == '0) ||
                       ((count_q == CNT_W'(1)) && bus.sample_req));
        if (MSB_FIRST) begin
            next_slice  = cur_q[WORD_WIDTH-1 -: SAMPLE_WIDTH];
            cur_shifted = cur_q << SAMPLE_WIDTH;
        end else begin
            next_slice  = cur_q[SAMPLE_WIDTH-1:0];
            cur_shifted = cur_q >> SAMPLE_WIDTH;
        end
    end

    assign bus.fifo_rd_req = start_fetch;
    assign fetch_state     = state_q;

    // Fetch FSM and prefetch register. F_WAIT is the single cycle in which
    // the requested word is on fifo_rd_data; only one read is ever in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= F_IDLE;
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
        end else begin
            if (load_cur) begin
                pf_valid_q <= 1'b0;
            end
            case (state_q)
                F_IDLE: begin
                    if (start_fetch) begin
                        state_q <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    pf_q       <= bus.fifo_rd_data;
                    pf_valid_q <= 1'b1;
                    state_q    <= F_IDLE;
                end
                default: state_q <= F_IDLE;
            endcase
        end
    end

    // Current word, sample output and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q            <= '0;
            count_q          <= '0;
            bus.sample_out   <= '0;
            bus.sample_valid <= 1'b0;
            bus.underrun     <= 1'b0;
        end else begin
            if (load_cur) begin
                cur_q   <= pf_q;
                count_q <= CNT_W'(SPW);
            end else if (take_sample) begin
                cur_q   <= cur_shifted;
                count_q <= count_q - CNT_W'(1);
            end
            if (take_sample) begin
                bus.sample_out <= next_slice;
            end
            bus.sample_valid <= take_sample;
            bus.underrun     <= bus.sample_req && (count_q == '0);
        end
    end

`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (bus.underrun && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_unpacker.sv
// tb_sample_unpacker: directed bench for sample_unpacker (SAMPLE_WIDTH=2).
// Two instances run side by side on the same request stream: u_msb with
// MSB_FIRST=1 and u_lsb with MSB_FIRST=0, each fed by its own FIFO model.
// With SAMPLE_UNPACKER_UNDERRUN_CNT_EN defined the underrun counter is also
// exercised, including saturation.
module tb_sample_unpacker;
    import gps_feed_pkg::*;

    localparam int W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        sample_req = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_word = '0;

    sample_unpacker_if #(.SAMPLE_WIDTH(W)) a_if ();
    sample_unpacker_if #(.SAMPLE_WIDTH(W)) b_if ();

    fetch_state_t a_state;
    fetch_state_t b_state;
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
    logic [15:0] a_ucnt;
    logic [15:0] b_ucnt;
`endif

    sample_unpacker #(.SAMPLE_WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (a_if.master),
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        .underrun_count (a_ucnt),
`endif
        .fetch_state    (a_state)
    );

    sample_unpacker #(.SAMPLE_WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (b_if.master),
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        .underrun_count (b_ucnt),
`endif
        .fetch_state    (b_state)
    );

    // ---------------- FIFO models (non show-ahead) ----------------
    logic [15:0] fifo_a[$];
    logic [15:0] fifo_b[$];
    logic        a_empty = 1'b1;
    logic        b_empty = 1'b1;
    logic [15:0] a_rd_data = '0;
    logic [15:0] b_rd_data = '0;

    assign a_if.fifo_rd_empty = a_empty;
    assign a_if.fifo_rd_data  = a_rd_data;
    assign a_if.sample_req    = sample_req;
    assign b_if.fifo_rd_empty = b_empty;
    assign b_if.fifo_rd_data  = b_rd_data;
    assign b_if.sample_req    = sample_req;

    always @(posedge clk) begin
        if (load_en) begin
            fifo_a.push_back(load_word);
            fifo_b.push_back(load_word);
        end
        if (a_if.fifo_rd_req && fifo_a.size() > 0) a_rd_data <= fifo_a.pop_front();
        if (b_if.fifo_rd_req && fifo_b.size() > 0) b_rd_data <= fifo_b.pop_front();
        a_empty <= (fifo_a.size() == 0);
        b_empty <= (fifo_b.size() == 0);
    end

    // ---------------- monitor ----------------
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [W-1:0] got_a[$];
    logic [W-1:0] got_b[$];
    int vcyc_a[$];
    int ucyc_a[$];
    int ucyc_b[$];
    int rdcyc_a[$];
    int viol = 0;

    always @(negedge clk) begin
        if (a_if.sample_valid) begin
            got_a.push_back(a_if.sample_out);
            vcyc_a.push_back(cycle);
        end
        if (b_if.sample_valid) got_b.push_back(b_if.sample_out);
        if (a_if.underrun) ucyc_a.push_back(cycle);
        if (b_if.underrun) ucyc_b.push_back(cycle);
        if (a_if.fifo_rd_req) rdcyc_a.push_back(cycle);
        if ((a_if.fifo_rd_req && a_empty) || (b_if.fifo_rd_req && b_empty)) viol <= viol + 1;
        if ((a_if.sample_valid && a_if.underrun) || (b_if.sample_valid && b_if.underrun))
            viol <= viol + 1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx >= 0 && idx < q.size()) return q[idx];
        return -1000;
    endfunction

    // Slice idx of a word counted from bit 0 upward.
    function automatic logic [W-1:0] lsb_model(input logic [15:0] w, input int idx);
        logic [15:0] t;
        t = w >> (W * idx);
        return t[W-1:0];
    endfunction

    // Compare the collected samples from index base against exp_q, emptying it.
    task automatic drain(input string tag, input bit use_b, input int base);
        int i;
        logic [W-1:0] e;
        logic [W-1:0] g;
        i = base;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (use_b) g = (i < got_b.size()) ? got_b[i] : 'x;
            else       g = (i < got_a.size()) ? got_a[i] : 'x;
            check(tag, 32'(g), 32'(e));
            i++;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] w);
        load_en   = 1'b1;
        load_word = w;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int ga, gb, va, ua, ub, ra;
        int wait_n;

        // Reset state
        tick(3);
        check("rst_sample_out", 32'(a_if.sample_out), 32'd0);
        check("rst_sample_valid", 32'(a_if.sample_valid), 32'd0);
        check("rst_underrun", 32'(a_if.underrun), 32'd0);
        check("rst_fifo_rd_req", 32'(a_if.fifo_rd_req), 32'd0);
        check("rst_state", 32'(a_state), 32'(F_IDLE));
        check("rst_b_valid", 32'(b_if.sample_valid), 32'd0);
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        check("rst_underrun_count", 32'(a_ucnt), 32'd0);
`endif
        reset_n = 1'b1;
        tick(1);

        // Empty FIFO, five isolated requests -> five underruns, no samples
        ua = ucyc_a.size(); ub = ucyc_b.size(); va = vcyc_a.size(); gb = got_b.size();
        for (int i = 0; i < 5; i++) begin
            sample_req = 1'b1; tick(1);
            sample_req = 1'b0; tick(1);
        end
        tick(2);
        check("empty_underruns_a", 32'(ucyc_a.size() - ua), 32'd5);
        check("empty_underruns_b", 32'(ucyc_b.size() - ub), 32'd5);
        check("empty_valids_a", 32'(vcyc_a.size() - va), 32'd0);
        check("empty_valids_b", 32'(got_b.size() - gb), 32'd0);
`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        check("empty_underrun_count_a", 32'(a_ucnt), 32'd5);
        check("empty_underrun_count_b", 32'(b_ucnt), 32'd5);
`endif

        // One word 16'hE41B, request every cycle
        ga = got_a.size(); gb = got_b.size(); va = vcyc_a.size();
        ua = ucyc_a.size(); ra = rdcyc_a.size();
        sample_req = 1'b1;
        load(16'hE41B);
        tick(16);
        sample_req = 1'b0;
        tick(2);
        check("e41b_count_a", 32'(got_a.size() - ga), 32'd8);
        check("e41b_count_b", 32'(got_b.size() - gb), 32'd8);
        exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        drain("e41b_msb", 1'b0, ga);
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb_model(16'hE41B, i));
        drain("e41b_lsb", 1'b1, gb);
        check("e41b_contiguous", 32'(qget(vcyc_a, va + 7) - qget(vcyc_a, va)), 32'd7);
        check("startup_latency", 32'(qget(vcyc_a, va) - qget(rdcyc_a, ra)), 32'd4);
        check("e41b_reads", 32'(rdcyc_a.size() - ra), 32'd1);
        check("e41b_underruns", 32'(ucyc_a.size() - ua), 32'd9);
        check("e41b_underrun_after_last",
              32'(qget(ucyc_a, ucyc_a.size() - 1) > qget(vcyc_a, vcyc_a.size() - 1)), 32'd1);
        check("e41b_sample_out_held", 32'(a_if.sample_out), 32'd3);

        // Two words back to back: 16'hFFFF then 16'h0000
        ga = got_a.size(); gb = got_b.size(); va = vcyc_a.size(); ra = rdcyc_a.size();
        sample_req = 1'b1;
        load(16'hFFFF);
        load(16'h0000);
        tick(24);
        sample_req = 1'b0;
        tick(2);
        check("b2b_count_a", 32'(got_a.size() - ga), 32'd16);
        for (int i = 0; i < 8; i++) exp_q.push_back(2'd3);
        for (int i = 0; i < 8; i++) exp_q.push_back(2'd0);
        drain("b2b_msb", 1'b0, ga);
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb_model(16'hFFFF, i));
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb_model(16'h0000, i));
        drain("b2b_lsb", 1'b1, gb);
        check("b2b_no_bubble", 32'(qget(vcyc_a, va + 15) - qget(vcyc_a, va)), 32'd15);
        check("b2b_reads", 32'(rdcyc_a.size() - ra), 32'd2);
        check("protocol_violations", 32'(viol), 32'd0);

        // Reset while a read is in flight
        load(16'hAAAA);
        wait_n = 0;
        while (a_state != F_WAIT && wait_n < 4) begin
            tick(1);
            wait_n++;
        end
        check("inflight_reached_wait", 32'(a_state), 32'(F_WAIT));
        reset_n = 1'b0;
        #1;
        check("async_reset_state", 32'(a_state), 32'(F_IDLE));
        check("async_reset_valid", 32'(a_if.sample_valid), 32'd0);
        tick(1);
        load(16'h1234);
        tick(2);
        check("rst_hold_rd_req", 32'(a_if.fifo_rd_req), 32'd0);
        check("rst_hold_sample_out", 32'(a_if.sample_out), 32'd0);
        check("rst_hold_underrun", 32'(a_if.underrun), 32'd0);
        check("rst_hold_state", 32'(a_state), 32'(F_IDLE));
        ga = got_a.size(); gb = got_b.size();
        sample_req = 1'b1;
        reset_n = 1'b1;
        tick(16);
        sample_req = 1'b0;
        tick(2);
        check("after_rst_count_a", 32'(got_a.size() - ga), 32'd8);
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
        drain("after_rst_msb", 1'b0, ga);
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb_model(16'h1234, i));
        drain("after_rst_lsb", 1'b1, gb);
        check("protocol_violations_end", 32'(viol), 32'd0);

`ifdef SAMPLE_UNPACKER_UNDERRUN_CNT_EN
        // Underrun counter saturation
        sample_req = 1'b1;
        tick(70000);
        check("underrun_count_sat", 32'(a_ucnt), 32'h0000FFFF);
        tick(10);
        check("underrun_count_sat_hold", 32'(a_ucnt), 32'h0000FFFF);
        sample_req = 1'b0;
        tick(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
